// File: rtl/known_ch_table.sv
// Known cluster-head table for EER-RL routing: stores advertised CHs, ages them per
// heartbeat round, and continuously registers the best CH (highest Q-value) and its hop count.
module known_ch_table #(
    parameter int WORD_WIDTH  = 16,
    parameter int NUM_ENTRIES = 5
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en_KCH,
    input  logic                  HB_reset,
    input  logic [WORD_WIDTH-1:0] HB_CHlimit,
    input  logic [WORD_WIDTH-1:0] fCH_ID,
    input  logic [WORD_WIDTH-1:0] fCH_Hops,
    input  logic [WORD_WIDTH-1:0] fCH_QValue,
    output logic [WORD_WIDTH-1:0] chosenCH,
    output logic [WORD_WIDTH-1:0] hopsfromCH
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [WORD_WIDTH-1:0] ALL_ONES = {WORD_WIDTH{1'b1}};

    logic                  ent_valid [NUM_ENTRIES];
    logic [WORD_WIDTH-1:0] ent_id    [NUM_ENTRIES];
    logic [WORD_WIDTH-1:0] ent_hops  [NUM_ENTRIES];
    logic [WORD_WIDTH-1:0] ent_q     [NUM_ENTRIES];
    logic [WORD_WIDTH-1:0] ent_age   [NUM_ENTRIES];

    logic                  valid_aged [NUM_ENTRIES];
    logic [WORD_WIDTH-1:0] age_aged   [NUM_ENTRIES];
    logic [WORD_WIDTH-1:0] age_inc    [NUM_ENTRIES];

    logic                  valid_nxt [NUM_ENTRIES];
    logic [WORD_WIDTH-1:0] id_nxt    [NUM_ENTRIES];
    logic [WORD_WIDTH-1:0] hops_nxt  [NUM_ENTRIES];
    logic [WORD_WIDTH-1:0] q_nxt     [NUM_ENTRIES];
    logic [WORD_WIDTH-1:0] age_nxt   [NUM_ENTRIES];

    logic             write_ok;
    logic             match_hit;
    logic [IDX_W-1:0] match_idx;
    logic             free_hit;
    logic [IDX_W-1:0] free_idx;
    logic             vic_found;
    logic [IDX_W-1:0] vic_idx;
    logic [WORD_WIDTH-1:0] vic_q;
    logic             do_write;
    logic [IDX_W-1:0] tgt_idx;

    logic                  sel_found;
    logic [WORD_WIDTH-1:0] sel_id;
    logic [WORD_WIDTH-1:0] sel_hops;
    logic [WORD_WIDTH-1:0] sel_q;

    // Heartbeat aging: saturating increment, drop once the limit is reached (limit 0 = never).
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            age_inc[i]    = (ent_age[i] == ALL_ONES) ? ent_age[i] : ent_age[i] + WORD_WIDTH'(1);
            valid_aged[i] = ent_valid[i];
            age_aged[i]   = ent_age[i];
            if (HB_reset && ent_valid[i]) begin
                age_aged[i]   = age_inc[i];
                valid_aged[i] = !((HB_CHlimit != '0) && (age_inc[i] >= HB_CHlimit));
            end
        end
    end

    // Refresh matches against pre-aging validity so a same-cycle refresh rescues the entry;
    // free-slot and victim search see the table after aging has been applied.
    always_comb begin
        write_ok  = en_KCH && (fCH_ID != '0) && (fCH_Hops != ALL_ONES);
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        vic_found = 1'b0;
        vic_idx   = '0;
        vic_q     = ALL_ONES;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!match_hit && ent_valid[i] && (ent_id[i] == fCH_ID)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!free_hit && !valid_aged[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (valid_aged[i] && (!vic_found || (ent_q[i] < vic_q))) begin
                vic_found = 1'b1;
                vic_idx   = IDX_W'(i);
                vic_q     = ent_q[i];
            end
        end

        do_write = 1'b0;
        tgt_idx  = '0;
        if (write_ok) begin
            if (match_hit) begin
                do_write = 1'b1;
                tgt_idx  = match_idx;
            end else if (free_hit) begin
                do_write = 1'b1;
                tgt_idx  = free_idx;
            end else if (vic_found && (fCH_QValue > vic_q)) begin
                do_write = 1'b1;
                tgt_idx  = vic_idx;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            valid_nxt[i] = valid_aged[i];
            age_nxt[i]   = age_aged[i];
            id_nxt[i]    = ent_id[i];
            hops_nxt[i]  = ent_hops[i];
            q_nxt[i]     = ent_q[i];
            if (do_write && (tgt_idx == IDX_W'(i))) begin
                valid_nxt[i] = 1'b1;
                age_nxt[i]   = '0;
                id_nxt[i]    = fCH_ID;
                hops_nxt[i]  = fCH_Hops;
                q_nxt[i]     = fCH_QValue;
            end
        end
    end

    // Best CH: highest Q, then fewer hops, then lowest index (strict compares keep the earlier slot).
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        sel_hops  = ALL_ONES;
        sel_q     = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent_valid[i] && (!sel_found || (ent_q[i] > sel_q) ||
                                 ((ent_q[i] == sel_q) && (ent_hops[i] < sel_hops)))) begin
                sel_found = 1'b1;
                sel_id    = ent_id[i];
                sel_hops  = ent_hops[i];
                sel_q     = ent_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_valid[i] <= 1'b0;
                ent_id[i]    <= '0;
                ent_hops[i]  <= '0;
                ent_q[i]     <= '0;
                ent_age[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_valid[i] <= valid_nxt[i];
                ent_id[i]    <= id_nxt[i];
                ent_hops[i]  <= hops_nxt[i];
                ent_q[i]     <= q_nxt[i];
                ent_age[i]   <= age_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            chosenCH   <= '0;
            hopsfromCH <= ALL_ONES;
        end else begin
            chosenCH   <= sel_id;
            hopsfromCH <= sel_hops;
        end
    end

endmodule

// File: tb/tb_known_ch_table.sv
// Directed self-checking bench for known_ch_table: insert, selection, replacement, aging, reset.
module tb_known_ch_table;

    logic        clk;
    logic        nrst;
    logic        en_KCH;
    logic        HB_reset;
    logic [15:0] HB_CHlimit;
    logic [15:0] fCH_ID;
    logic [15:0] fCH_Hops;
    logic [15:0] fCH_QValue;
    logic [15:0] chosenCH;
    logic [15:0] hopsfromCH;

    int checks   = 0;
    int failures = 0;

    known_ch_table #(.WORD_WIDTH(16), .NUM_ENTRIES(5)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .en_KCH     (en_KCH),
        .HB_reset   (HB_reset),
        .HB_CHlimit (HB_CHlimit),
        .fCH_ID     (fCH_ID),
        .fCH_Hops   (fCH_Hops),
        .fCH_QValue (fCH_QValue),
        .chosenCH   (chosenCH),
        .hopsfromCH (hopsfromCH)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All stimulus is applied at the falling edge; the write is sampled by the next rising edge.
    task automatic wr(input logic [15:0] id, input logic [15:0] hops, input logic [15:0] q);
        en_KCH     = 1'b1;
        fCH_ID     = id;
        fCH_Hops   = hops;
        fCH_QValue = q;
        @(negedge clk);
        en_KCH     = 1'b0;
        fCH_Hops   = 16'hFFFF;
    endtask

    task automatic hb_pulse();
        HB_reset = 1'b1;
        @(negedge clk);
        HB_reset = 1'b0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        nrst = 1'b0; en_KCH = 1'b0; HB_reset = 1'b0; HB_CHlimit = 16'd0;
        fCH_ID = 16'd0; fCH_Hops = 16'hFFFF; fCH_QValue = 16'd0;
        #20;
        checks++;
        if (chosenCH !== 16'h0000 || hopsfromCH !== 16'hFFFF) begin
            failures++;
            $display("FAIL reset_active: got %h/%h expected 0000/ffff", chosenCH, hopsfromCH);
        end
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (chosenCH !== 16'h0000 || hopsfromCH !== 16'hFFFF) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got %h/%h expected 0000/ffff", i, chosenCH, hopsfromCH);
            end
        end
    endtask

    task automatic test_single_insert();
        wr(16'd3, 16'd2, 16'h0100);
        checks++;
        if (chosenCH !== 16'h0000 || hopsfromCH !== 16'hFFFF) begin
            failures++;
            $display("FAIL insert_latency: got %h/%h expected 0000/ffff", chosenCH, hopsfromCH);
        end
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0003 || hopsfromCH !== 16'h0002) begin
            failures++;
            $display("FAIL insert: got %h/%h expected 0003/0002", chosenCH, hopsfromCH);
        end
        wr(16'd0, 16'd1, 16'h0900);
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0003 || hopsfromCH !== 16'h0002) begin
            failures++;
            $display("FAIL ignore_id0: got %h/%h expected 0003/0002", chosenCH, hopsfromCH);
        end
        wr(16'd8, 16'hFFFF, 16'h0900);
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0003 || hopsfromCH !== 16'h0002) begin
            failures++;
            $display("FAIL ignore_hops_ffff: got %h/%h expected 0003/0002", chosenCH, hopsfromCH);
        end
    endtask

    task automatic test_best_select();
        do_reset();
        wr(16'd3, 16'd2, 16'h0100);
        wr(16'd7, 16'd4, 16'h0200);
        wr(16'd9, 16'd1, 16'h0200);
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0009 || hopsfromCH !== 16'h0001) begin
            failures++;
            $display("FAIL best_tie_hops: got %h/%h expected 0009/0001", chosenCH, hopsfromCH);
        end
        wr(16'd7, 16'd4, 16'h0300);
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0007 || hopsfromCH !== 16'h0004) begin
            failures++;
            $display("FAIL best_update: got %h/%h expected 0007/0004", chosenCH, hopsfromCH);
        end
    endtask

    task automatic test_full_table();
        do_reset();
        for (int i = 1; i <= 5; i++) wr(16'(i), 16'(i), 16'(i * 10));
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0005 || hopsfromCH !== 16'h0005) begin
            failures++;
            $display("FAIL full_fill: got %h/%h expected 0005/0005", chosenCH, hopsfromCH);
        end
        wr(16'd6, 16'd1, 16'd5);
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0005 || hopsfromCH !== 16'h0005) begin
            failures++;
            $display("FAIL full_drop_low: got %h/%h expected 0005/0005", chosenCH, hopsfromCH);
        end
        wr(16'd6, 16'd1, 16'd60);
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0006 || hopsfromCH !== 16'h0001) begin
            failures++;
            $display("FAIL full_replace: got %h/%h expected 0006/0001", chosenCH, hopsfromCH);
        end
        // Lower everyone else to Q=1 and ID 6 to Q=2: a surviving ID 1 (Q=10) would win.
        for (int i = 2; i <= 5; i++) wr(16'(i), 16'd9, 16'd1);
        wr(16'd6, 16'd9, 16'd2);
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0006 || hopsfromCH !== 16'h0009) begin
            failures++;
            $display("FAIL full_victim_id1: got %h/%h expected 0006/0009", chosenCH, hopsfromCH);
        end
    endtask

    task automatic test_aging();
        do_reset();
        HB_CHlimit = 16'd2;
        wr(16'd3, 16'd2, 16'h0100);
        hb_pulse();
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0003 || hopsfromCH !== 16'h0002) begin
            failures++;
            $display("FAIL aging_one_round: got %h/%h expected 0003/0002", chosenCH, hopsfromCH);
        end
        hb_pulse();
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0000 || hopsfromCH !== 16'hFFFF) begin
            failures++;
            $display("FAIL aging_drop: got %h/%h expected 0000/ffff", chosenCH, hopsfromCH);
        end
        HB_CHlimit = 16'd0;
        wr(16'd3, 16'd2, 16'h0100);
        for (int i = 0; i < 4; i++) hb_pulse();
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0003 || hopsfromCH !== 16'h0002) begin
            failures++;
            $display("FAIL aging_disabled: got %h/%h expected 0003/0002", chosenCH, hopsfromCH);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        HB_CHlimit = 16'd1;
        wr(16'd3, 16'd2, 16'h0100);
        HB_reset = 1'b1;
        wr(16'd3, 16'd2, 16'h0150);
        HB_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0003 || hopsfromCH !== 16'h0002) begin
            failures++;
            $display("FAIL simul_refresh: got %h/%h expected 0003/0002", chosenCH, hopsfromCH);
        end
        hb_pulse();
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0000 || hopsfromCH !== 16'hFFFF) begin
            failures++;
            $display("FAIL simul_age_zero: got %h/%h expected 0000/ffff", chosenCH, hopsfromCH);
        end
        HB_CHlimit = 16'd0;
        wr(16'd4, 16'd3, 16'h0040);
        wr(16'd5, 16'd6, 16'h0080);
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0005 || hopsfromCH !== 16'h0006) begin
            failures++;
            $display("FAIL midrun_before: got %h/%h expected 0005/0006", chosenCH, hopsfromCH);
        end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if (chosenCH !== 16'h0000 || hopsfromCH !== 16'hFFFF) begin
            failures++;
            $display("FAIL midrun_async: got %h/%h expected 0000/ffff", chosenCH, hopsfromCH);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (chosenCH !== 16'h0000 || hopsfromCH !== 16'hFFFF) begin
            failures++;
            $display("FAIL midrun_empty: got %h/%h expected 0000/ffff", chosenCH, hopsfromCH);
        end
    endtask

    initial begin
        test_reset();
        test_single_insert();
        test_best_select();
        test_full_table();
        test_aging();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/known_ch_table.md
Name:
known_ch_table

Overview:
- Known-cluster-head (CH) table for a WSN node running the EER-RL routing protocol.
- Stores the cluster heads heard in CH advertisements: ID, hop count and Q-value for each.
- Ages entries out on heartbeat rounds.
- Continuously outputs the best CH (highest Q-value) and the hop distance to it, for the routing/packet-forming logic.

Parameters:
- WORD_WIDTH, 16, width of the ID, hops, Q-value and limit fields.
- NUM_ENTRIES, 5, number of table slots.

Ports:
- clk  input  1  system clock, rising-edge.
- nrst  input  1  reset, asynchronous, active-low.
- en_KCH  input  1  write strobe; the fCH_* fields are valid this cycle.
- HB_reset  input  1  one-cycle pulse marking a new heartbeat round (ages entries).
- HB_CHlimit  input  WORD_WIDTH  heartbeat rounds without refresh before an entry is dropped; 0 disables aging.
- fCH_ID  input  WORD_WIDTH  advertised CH ID.
- fCH_Hops  input  WORD_WIDTH  hops to the advertised CH.
- fCH_QValue  input  WORD_WIDTH  Q-value of the advertised CH, unsigned.
- chosenCH  output  WORD_WIDTH  ID of the selected CH.
- hopsfromCH  output  WORD_WIDTH  hops to the selected CH.

Behaviour:
- Reset (nrst=0, asynchronous): all entries invalid, all ages 0; chosenCH=16'h0000, hopsfromCH=16'hFFFF.
  - Outputs hold these values until the first valid write propagates.
- Entry contents: valid bit, ID, hops, Q-value, age counter (WORD_WIDTH bits, saturating).
- Write, on a rising edge with en_KCH=1:
  - Ignored if fCH_ID==0 or fCH_Hops==16'hFFFF.
  - If a valid entry has ID==fCH_ID: overwrite its hops and Q-value; age=0.
  - Else, if a free slot exists: fill the lowest-index free slot; valid=1, age=0.
  - Else (table full): find the valid entry with the lowest Q-value (ties go to the lowest index). Replace it only if fCH_QValue is strictly greater; otherwise drop the advertisement.
- Aging, on a rising edge with HB_reset=1:
  - Every valid entry's age increments, saturating.
  - If HB_CHlimit!=0 and the new age >= HB_CHlimit, the entry becomes invalid.
- HB_reset and en_KCH in the same cycle:
  - Aging is applied first, then the write.
  - The written or refreshed entry ends with age=0 and valid=1, even if aging would have dropped it.
- Selection:
  - Combinational over the valid entries: highest Q-value wins; ties go to fewer hops, then lowest index.
  - Result is registered into chosenCH/hopsfromCH on every rising edge.
  - Latency: a write sampled at edge k is visible on the outputs after edge k+1.
- No valid entries: outputs return to 16'h0000 / 16'hFFFF on the next edge.
- en_KCH=0 and HB_reset=0: table unchanged; outputs stable.
- Arithmetic: all comparisons unsigned at WORD_WIDTH; no wrap-around of the age counter.

Test Plan:
- Reset hold: nrst=0 for 4 half-cycles with en_KCH=0, fCH_Hops=FFFF, then release with no stimulus → chosenCH=0000, hopsfromCH=FFFF throughout.
- Single insert: write ID=3, hops=2, Q=0x0100 → after 2 edges chosenCH=0003, hopsfromCH=0002. A write with ID=0 or hops=FFFF → table and outputs unchanged.
- Best selection: insert (3,2,0x0100), (7,4,0x0200), (9,1,0x0200) → chosenCH=0009, hopsfromCH=0001 (Q tie broken by hops). Update ID 7 to Q=0x0300 → chosenCH=0007, hopsfromCH=0004.
- Full table: fill 5 entries with Q=10,20,30,40,50 (IDs 1..5).
  - Write ID=6, Q=5 → dropped.
  - Write ID=6, Q=60 → replaces ID 1; chosenCH=0006.
- Aging: HB_CHlimit=2, insert ID=3, pulse HB_reset twice → entry dropped; outputs return to 0000/FFFF. With HB_CHlimit=0 → entry never dropped.
- Simultaneous events: HB_CHlimit=1, entry ID=3 present, HB_reset and en_KCH(ID=3) in the same cycle → ID 3 stays valid with age 0. Assert nrst mid-run → outputs immediately 0000/FFFF and table empty.
